// File: rtl/complex_sched_pkg.sv
// ---------------------------------------------------------------------------
// complex_sched_pkg
//   Shared definitions for the complex matrix-by-vector row scheduler:
//   default widths, chunk size, the scheduler state encoding and a
//   saturating-increment helper used by the optional statistics counters.
// ---------------------------------------------------------------------------
package complex_sched_pkg;

  localparam int NI_DEF     = 8;   // complex elements per chunk
  localparam int ROW_W_DEF  = 16;  // row count / row index width
  localparam int ADDR_W_DEF = 20;  // chunk fetch address width
  localparam int ELEM_W_DEF = 64;  // complex result word width

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_FEED     = 3'd2,
    ST_WAIT_ROW = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_FINISH   = 3'd5
  } sched_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/complex_sched_addr_gen.sv
// ---------------------------------------------------------------------------
// complex_sched_addr_gen
//   Row and chunk counters plus the chunk fetch address.
//   fetch_addr = row * n_multiples + chunk (mod 2**ADDR_W), built
//   incrementally: a row base advances by n_multiples per row and the
//   address itself advances by one per granted chunk, so no multiplier.
// Ports
//   clk, reset    clock / asynchronous active-high reset
//   clear         accepted start: row and row base back to 0
//   launch        row launch: chunk to 0, address reloaded from row base
//   grant         one chunk granted: chunk and address advance
//   next_row      current row finished and another follows
//   n_multiples   latched chunks per row
//   n_rows        latched row count
//   row           current row index
//   fetch_addr    registered chunk fetch address
//   chunk_done    every chunk of the current row has been granted
//   last_row      current row is the final one
// ---------------------------------------------------------------------------
module complex_sched_addr_gen
  import complex_sched_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              launch,
  input  logic              grant,
  input  logic              next_row,
  input  logic [31:0]       n_multiples,
  input  logic [ROW_W-1:0]  n_rows,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              chunk_done,
  output logic              last_row
);

  logic [ROW_W-1:0]  row_reg;
  logic [31:0]       chunk_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic [ADDR_W-1:0] fetch_addr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_reg        <= '0;
      chunk_reg      <= '0;
      row_base_reg   <= '0;
      fetch_addr_reg <= '0;
    end else begin
      if (clear) begin
        row_reg      <= '0;
        row_base_reg <= '0;
      end else if (next_row) begin
        row_reg      <= row_reg + ROW_W'(1);
        // Truncation to ADDR_W is intentional; overflow wraps silently.
        row_base_reg <= row_base_reg + n_multiples[ADDR_W-1:0];
      end

      if (launch) begin
        chunk_reg      <= '0;
        fetch_addr_reg <= row_base_reg;
      end else if (grant) begin
        chunk_reg      <= chunk_reg + 32'd1;
        fetch_addr_reg <= fetch_addr_reg + ADDR_W'(1);
      end
    end
  end

  assign row        = row_reg;
  assign fetch_addr = fetch_addr_reg;
  assign chunk_done = (chunk_reg >= n_multiples);
  // Compare one bit wider so n_rows at full scale cannot alias.
  assign last_row   = (({1'b0, row_reg} + {{ROW_W{1'b0}}, 1'b1}) == {1'b0, n_rows});

endmodule

// File: rtl/complex_mxv_row_scheduler.sv
// ---------------------------------------------------------------------------
// complex_mxv_row_scheduler
//   Walks the complex row-by-vector engine over a whole matrix, one row at a
//   time and n_multiples chunks of NI elements per row. Issues chunk fetches,
//   pulses the engine's row start, gates chunk transfers with you_can_read
//   and writes each row's dot product into the result buffer.
//
//   Optional build macro: COMPLEX_SCHED_STATS_EN adds stat_cycles (busy
//   cycles) and stat_stalls (FEED cycles with I_am_ready low). Without it the
//   ports and counters do not exist.
//
// Ports
//   clk, reset            clock / asynchronous active-high reset
//   start                 begin a matrix pass (n_rows, n_multiples sampled)
//   busy / done           pass in progress / 1-cycle completion pulse
//   cfg_err               1-cycle pulse: start rejected, n_multiples == 0
//   proto_err             sticky engine protocol violation, cleared by start
//   fetch_req/addr/gnt    chunk fetch handshake to matrix/vector memory
//   start_row_by_vector   1-cycle pulse at the start of each row
//   no_of_multiples       latched chunks per row for the engine
//   you_can_read          engine may consume the chunk on its bus this cycle
//   I_am_ready            engine can take another chunk
//   give_me_only          engine has accumulated every chunk of the row
//   decoder_read_now      engine result valid this cycle
//   result                engine result word
//   res_we/addr/data      result buffer write port
// ---------------------------------------------------------------------------
module complex_mxv_row_scheduler
  import complex_sched_pkg::*;
#(
  parameter int NI            = NI_DEF,
  parameter int element_width = ELEM_W_DEF,
  parameter int ROW_W         = ROW_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ROW_W-1:0]         n_rows,
  input  logic [31:0]              n_multiples,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output logic                     proto_err,
  output logic                     fetch_req,
  output logic [ADDR_W-1:0]        fetch_addr,
  input  logic                     fetch_gnt,
  output logic                     start_row_by_vector,
  output logic [31:0]              no_of_multiples,
  output logic                     you_can_read,
  input  logic                     I_am_ready,
  input  logic                     give_me_only,
  input  logic                     decoder_read_now,
  input  logic [element_width-1:0] result,
  output logic                     res_we,
  output logic [ROW_W-1:0]         res_addr,
  output logic [element_width-1:0] res_data
`ifdef COMPLEX_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_cycles,
  output logic [31:0]              stat_stalls
`endif
);

  sched_state_t state_reg, state_next;

  logic [31:0]              n_mult_reg, n_mult_next;
  logic [ROW_W-1:0]         n_rows_reg, n_rows_next;
  logic                     done_reg, done_next;
  logic                     cfg_err_reg, cfg_err_next;
  logic                     proto_err_reg, proto_err_next;
  logic                     you_can_read_reg;
  logic                     res_we_reg, res_we_next;
  logic [ROW_W-1:0]         res_addr_reg, res_addr_next;
  logic [element_width-1:0] res_data_reg, res_data_next;

  logic             clear, launch, next_row, capture, grant;
  logic [ROW_W-1:0] row;
  logic             chunk_done, last_row;

  complex_sched_addr_gen #(
    .ROW_W  (ROW_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .launch      (launch),
    .grant       (grant),
    .next_row    (next_row),
    .n_multiples (n_mult_reg),
    .n_rows      (n_rows_reg),
    .row         (row),
    .fetch_addr  (fetch_addr),
    .chunk_done  (chunk_done),
    .last_row    (last_row)
  );

  // Requests drop in the same cycle I_am_ready falls; a grant seen while the
  // request is still up is counted, and its data follows one cycle later.
  assign fetch_req = (state_reg == ST_FEED) && I_am_ready && !chunk_done;
  assign grant     = fetch_req && fetch_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      n_mult_reg       <= '0;
      n_rows_reg       <= '0;
      done_reg         <= 1'b0;
      cfg_err_reg      <= 1'b0;
      proto_err_reg    <= 1'b0;
      you_can_read_reg <= 1'b0;
      res_we_reg       <= 1'b0;
      res_addr_reg     <= '0;
      res_data_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      n_mult_reg       <= n_mult_next;
      n_rows_reg       <= n_rows_next;
      done_reg         <= done_next;
      cfg_err_reg      <= cfg_err_next;
      proto_err_reg    <= proto_err_next;
      you_can_read_reg <= grant;
      res_we_reg       <= res_we_next;
      res_addr_reg     <= res_addr_next;
      res_data_reg     <= res_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    n_mult_next    = n_mult_reg;
    n_rows_next    = n_rows_reg;
    done_next      = 1'b0;
    cfg_err_next   = 1'b0;
    proto_err_next = proto_err_reg;
    res_we_next    = 1'b0;
    res_addr_next  = res_addr_reg;
    res_data_next  = res_data_reg;
    clear          = 1'b0;
    launch         = 1'b0;
    next_row       = 1'b0;
    capture        = 1'b0;

    // Protocol checks: row completion while chunks are still being fed, or
    // a result outside the window where one is expected (never written).
    if ((state_reg == ST_FEED) && give_me_only) begin
      proto_err_next = 1'b1;
    end
    if (decoder_read_now && (state_reg != ST_WAIT_ROW) && (state_reg != ST_DRAIN)) begin
      proto_err_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (n_multiples == '0) begin
            cfg_err_next = 1'b1;
          end else if (n_rows == '0) begin
            done_next = 1'b1;          // empty matrix: done without going busy
          end else begin
            n_mult_next    = n_multiples;
            n_rows_next    = n_rows;
            proto_err_next = 1'b0;
            clear          = 1'b1;
            state_next     = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        launch     = 1'b1;
        state_next = ST_FEED;
      end
      ST_FEED: begin
        // chunk_done first rises in the cycle carrying the last you_can_read.
        if (chunk_done) begin
          state_next = ST_WAIT_ROW;
        end
      end
      ST_WAIT_ROW: begin
        if (give_me_only) begin
          if (decoder_read_now) begin
            capture = 1'b1;            // result arrived with row-complete
          end else begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (decoder_read_now) begin
          capture = 1'b1;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (capture) begin
      res_we_next   = 1'b1;
      res_addr_next = row;
      res_data_next = result;
      if (last_row) begin
        done_next  = 1'b1;             // done is high while in FINISH
        state_next = ST_FINISH;
      end else begin
        next_row   = 1'b1;
        state_next = ST_LAUNCH;
      end
    end
  end

  assign busy                = (state_reg != ST_IDLE) && (state_reg != ST_FINISH);
  assign done                = done_reg;
  assign cfg_err             = cfg_err_reg;
  assign proto_err           = proto_err_reg;
  assign start_row_by_vector = (state_reg == ST_LAUNCH);
  assign no_of_multiples     = n_mult_reg;
  assign you_can_read        = you_can_read_reg;
  assign res_we              = res_we_reg;
  assign res_addr            = res_addr_reg;
  assign res_data            = res_data_reg;

`ifdef COMPLEX_SCHED_STATS_EN
  logic [31:0] stat_cycles_reg;
  logic [31:0] stat_stalls_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cycles_reg <= '0;
      stat_stalls_reg <= '0;
    end else if (clear) begin
      stat_cycles_reg <= '0;
      stat_stalls_reg <= '0;
    end else begin
      if (busy) begin
        stat_cycles_reg <= sat_inc32(stat_cycles_reg);
      end
      if ((state_reg == ST_FEED) && !I_am_ready) begin
        stat_stalls_reg <= sat_inc32(stat_stalls_reg);
      end
    end
  end

  assign stat_cycles = stat_cycles_reg;
  assign stat_stalls = stat_stalls_reg;
`endif

endmodule

// File: tb/tb_complex_mxv_row_scheduler.sv
// ---------------------------------------------------------------------------
// tb_complex_mxv_row_scheduler
//   Table of matrix passes plus a mid-pass reset sequence. A small engine and
//   memory model answers the handshakes; expected fetch addresses and result
//   writes are queued when a pass is started and popped as the DUT emits them.
//   Build with COMPLEX_SCHED_STATS_EN to also check the statistics counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_complex_mxv_row_scheduler;

  localparam int ROW_W  = 16;
  localparam int ADDR_W = 20;
  localparam int EW     = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ROW_W-1:0]  n_rows = '0;
  logic [31:0]       n_multiples = '0;
  logic              busy, done, cfg_err, proto_err;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              start_row_by_vector;
  logic [31:0]       no_of_multiples;
  logic              you_can_read;
  logic              I_am_ready = 1'b1;
  logic              give_me_only = 1'b0;
  logic              decoder_read_now = 1'b0;
  logic [EW-1:0]     result = '0;
  logic              res_we;
  logic [ROW_W-1:0]  res_addr;
  logic [EW-1:0]     res_data;
`ifdef COMPLEX_SCHED_STATS_EN
  logic [31:0]       stat_cycles, stat_stalls;
`endif

  complex_mxv_row_scheduler #(
    .NI(8), .element_width(EW), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .n_rows              (n_rows),
    .n_multiples         (n_multiples),
    .busy                (busy),
    .done                (done),
    .cfg_err             (cfg_err),
    .proto_err           (proto_err),
    .fetch_req           (fetch_req),
    .fetch_addr          (fetch_addr),
    .fetch_gnt           (fetch_gnt),
    .start_row_by_vector (start_row_by_vector),
    .no_of_multiples     (no_of_multiples),
    .you_can_read        (you_can_read),
    .I_am_ready          (I_am_ready),
    .give_me_only        (give_me_only),
    .decoder_read_now    (decoder_read_now),
    .result              (result),
    .res_we              (res_we),
    .res_addr            (res_addr),
    .res_data            (res_data)
`ifdef COMPLEX_SCHED_STATS_EN
    ,
    .stat_cycles         (stat_cycles),
    .stat_stalls         (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Memory accepts every request immediately.
  assign fetch_gnt = fetch_req;

  typedef struct {
    int nr; int nm; int toggle; int merged; int force_early;
    int exp_cfg_err; int exp_done; int exp_starts; int exp_writes; int exp_proto;
  } vec_t;
  vec_t vecs[8];

  int n_checks = 0;
  int n_fail   = 0;

  // Model / monitor state
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int starts_seen = 0, writes_seen = 0, ycr_total = 0, done_cnt = 0, cfg_cnt = 0;
  int busy_seen = 0, rd_cnt = 0, in_feed = 0, exp_stalls = 0;
  int eng_phase = 0, eng_row = 0, cur_nm = 0;
  int toggle_mode = 0, merged_mode = 0, force_early = 0, early_pending = 0;
  int unsigned       exp_addr[$];
  int unsigned       exp_res_addr[$];
  logic [EW-1:0]     exp_res_data[$];

  function automatic logic [EW-1:0] res_fn(input int r);
    return 64'hC0DE_0000_0000_0000 + (64'(r) * 64'h0001_0001) + 64'd5;
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"},
          {busy, done, cfg_err, proto_err, fetch_req, start_row_by_vector,
           you_can_read, res_we, fetch_addr, res_addr}, 0);
    check({tag, "_no_of_multiples"}, no_of_multiples, 0);
    check({tag, "_res_data"}, res_data, 0);
  endtask

  // Engine model: drive on the falling edge, observe 1 ns later, well before
  // the next rising edge, so the observed values are what the DUT acts on.
  always @(negedge clk) begin
    int unsigned a;
    give_me_only     = 1'b0;
    decoder_read_now = 1'b0;
    I_am_ready       = (toggle_mode != 0) ? ~I_am_ready : 1'b1;
    if (eng_phase == 1) begin
      give_me_only = 1'b1;
      if (merged_mode != 0) begin
        decoder_read_now = 1'b1;
        result           = res_fn(eng_row);
        eng_phase        = 0;
      end else begin
        eng_phase = 2;
      end
    end else if (eng_phase == 2) begin
      decoder_read_now = 1'b1;
      result           = res_fn(eng_row);
      eng_phase        = 0;
    end
    if ((force_early != 0) && (early_pending != 0) && (rd_cnt == 2)) begin
      give_me_only  = 1'b1;
      early_pending = 0;
    end

    #1;
    cyc++;
    if (start)   start_cyc = cyc;
    if (busy)    busy_seen = 1;
    if (done)    begin done_cnt++; done_cyc = cyc; end
    if (cfg_err) cfg_cnt++;
    if ((in_feed != 0) && !I_am_ready) exp_stalls++;

    if (fetch_req && fetch_gnt) begin
      if (exp_addr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL fetch_extra: got addr %0d, expected no fetch", fetch_addr);
      end else begin
        a = exp_addr.pop_front();
        check("fetch_addr", fetch_addr, a);
      end
    end

    if (res_we) begin
      writes_seen++;
      if (exp_res_addr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL res_extra: got write row %0d, expected no write", res_addr);
      end else begin
        check("res_addr", res_addr, exp_res_addr.pop_front());
        check("res_data", res_data, exp_res_data.pop_front());
      end
      check("chunks_per_row", rd_cnt, cur_nm);
    end

    if (start_row_by_vector) begin
      eng_row = starts_seen;
      starts_seen++;
      rd_cnt  = 0;
      in_feed = 1;
      check("no_of_multiples", no_of_multiples, cur_nm);
    end

    if (you_can_read) begin
      ycr_total++;
      rd_cnt++;
      if (rd_cnt == cur_nm) begin
        eng_phase = 1;
        in_feed   = 0;
      end
    end
  end

  task automatic clear_model();
    starts_seen = 0; writes_seen = 0; ycr_total = 0; done_cnt = 0; cfg_cnt = 0;
    busy_seen = 0; rd_cnt = 0; in_feed = 0; exp_stalls = 0; eng_phase = 0;
    done_cyc = 0;
    exp_addr.delete(); exp_res_addr.delete(); exp_res_data.delete();
  endtask

  task automatic run_pass(input int i);
    vec_t v;
    int   waited;
    int   budget;
    v = vecs[i];
    @(posedge clk); #1;
    clear_model();
    toggle_mode   = v.toggle;
    merged_mode   = v.merged;
    force_early   = v.force_early;
    early_pending = v.force_early;
    cur_nm        = v.nm;
    if ((v.nm != 0) && (v.nr != 0)) begin
      for (int r = 0; r < v.nr; r++) begin
        for (int c = 0; c < v.nm; c++) exp_addr.push_back(r * v.nm + c);
        exp_res_addr.push_back(r);
        exp_res_data.push_back(res_fn(r));
      end
    end
    @(negedge clk);
    n_rows      = ROW_W'(v.nr);
    n_multiples = 32'(v.nm);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;

    budget = (v.exp_done != 0) ? 600 : 10;
    waited = 0;
    while ((done_cnt == 0) && (waited < budget)) begin
      @(posedge clk);
      waited++;
    end
    if ((v.exp_done != 0) && (done_cnt == 0)) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: pass %0d got no done within %0d cycles", i, budget);
    end
    repeat (5) @(posedge clk);
    #1;

    check("done_count",    done_cnt, v.exp_done);
    check("cfg_err_count", cfg_cnt, v.exp_cfg_err);
    check("row_starts",    starts_seen, v.exp_starts);
    check("result_writes", writes_seen, v.exp_writes);
    check("chunk_reads",   ycr_total, v.exp_starts * v.nm);
    check("fetch_left",    exp_addr.size(), 0);
    check("res_left",      exp_res_addr.size(), 0);
    check("proto_err",     proto_err, v.exp_proto);
    check("busy_after",    busy, 0);
    if ((v.nr == 0) || (v.nm == 0)) check("busy_never", busy_seen, 0);
    if ((v.nr == 0) && (v.exp_done != 0)) check("done_latency", done_cyc - start_cyc, 1);
`ifdef COMPLEX_SCHED_STATS_EN
    if (v.exp_starts != 0) begin
      check("stat_stalls", stat_stalls, exp_stalls);
      check("stat_cycles", stat_cycles, done_cyc - start_cyc - 1);
    end
`endif
    $display("pass %0d: n_rows=%0d n_mult=%0d toggle=%0d merged=%0d early=%0d -> done=%0d cfg_err=%0d rows=%0d writes=%0d reads=%0d proto_err=%0d",
             i, v.nr, v.nm, v.toggle, v.merged, v.force_early,
             done_cnt, cfg_cnt, starts_seen, writes_seen, ycr_total, proto_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    //            nr nm tog mrg early cfg done starts writes proto
    vecs[0] = '{3, 3, 0, 0, 0, 0, 1, 3, 3, 0};
    vecs[1] = '{2, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[2] = '{0, 5, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[3] = '{2, 4, 1, 0, 0, 0, 1, 2, 2, 0};
    vecs[4] = '{2, 4, 0, 0, 1, 0, 1, 2, 2, 1};
    vecs[5] = '{3, 2, 0, 1, 0, 0, 1, 3, 3, 0};
    vecs[6] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0};
    vecs[7] = '{2, 2, 0, 0, 0, 0, 1, 2, 2, 0};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("after_reset");

    for (int i = 0; i < 7; i++) run_pass(i);

    // Reset in the middle of row 1's chunk feed, then a clean pass.
    @(posedge clk); #1;
    clear_model();
    toggle_mode = 0; merged_mode = 0; force_early = 0; early_pending = 0;
    cur_nm = 4;
    for (int k = 0; k < 12; k++) exp_addr.push_back(k);
    for (int r = 0; r < 3; r++) begin
      exp_res_addr.push_back(r);
      exp_res_data.push_back(res_fn(r));
    end
    @(negedge clk);
    n_rows = 16'd3; n_multiples = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while ((starts_seen < 2) && (waited < 200)) begin
      @(posedge clk);
      waited++;
    end
    if (starts_seen < 2) begin
      n_checks++; n_fail++;
      $display("FAIL row1_timeout: got %0d row starts, expected 2", starts_seen);
    end
    @(negedge clk);
    reset = 1'b1;
    #2;
    check_all_zero("midpass_reset");
    done_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt, 0);
    check("idle_after_reset", busy, 0);
    $display("reset mid-pass: row starts before reset=%0d, done after reset=%0d", starts_seen, done_cnt);

    run_pass(7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
